// File: rtl/semaphore_head.sv
`default_nettype none
// ============================================================================
// Module   : semaphore_head
// Purpose  : Per-head lamp driver turning change pulses into timed
//            red/yellow/green sequences, with off-mode yellow flashing.
// Revision : 1.0 - initial release
// ============================================================================
module semaphore_head #(
    parameter int CYCLES_PER_SEC = 48000000,
    parameter int YELLOW_S       = 3,
    parameter int CNT_W          = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       set,
    input  logic       change,
    output logic       lamp_r,
    output logic       lamp_y,
    output logic       lamp_g,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    localparam int               PRE_W     = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(CYCLES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] C_YEL     = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RED   = 3'd1,
        S_GREEN = 3'd2,
        S_YEL2G = 3'd3,
        S_YEL2R = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_blink;
    logic             w_blink_nxt;
    logic             w_tick;
    logic             w_done_nxt;
    logic             w_yel_nxt;

    always_comb begin
        w_tick      = (r_pre == C_PRE_MAX);
        w_nxt       = r_state;
        w_cnt_nxt   = r_cnt;
        w_blink_nxt = r_blink;
        w_done_nxt  = 1'b0;
        if (!en) begin
            // Disable abandons any yellow timer; flashing starts dark.
            w_nxt = S_OFF;
            if (r_state == S_OFF) begin
                if (w_tick) begin
                    w_blink_nxt = ~r_blink;
                end
            end else begin
                w_blink_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_OFF: begin
                    w_nxt       = set ? S_RED : S_GREEN;
                    w_blink_nxt = 1'b0;
                end
                S_RED: begin
                    if (change) begin
                        w_nxt     = S_YEL2G;
                        w_cnt_nxt = C_YEL;
                    end
                end
                S_GREEN: begin
                    if (change) begin
                        w_nxt     = S_YEL2R;
                        w_cnt_nxt = C_YEL;
                    end
                end
                S_YEL2G, S_YEL2R: begin
                    if (w_tick) begin
                        w_cnt_nxt = r_cnt - C_ONE;
                        if (r_cnt == C_ONE) begin
                            w_nxt      = (r_state == S_YEL2G) ? S_GREEN : S_RED;
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_nxt       = S_OFF;
                    w_blink_nxt = 1'b0;
                end
            endcase
        end
        w_yel_nxt = (w_nxt == S_YEL2G) || (w_nxt == S_YEL2R);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_OFF;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_blink <= 1'b0;
            lamp_r  <= 1'b0;
            lamp_y  <= 1'b0;
            lamp_g  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_blink <= w_blink_nxt;
            // Restarting the prescaler on a state change makes every interval whole seconds.
            r_pre   <= ((w_nxt != r_state) || w_tick) ? '0 : r_pre + PRE_W'(1);
            lamp_r  <= (w_nxt == S_RED);
            lamp_g  <= (w_nxt == S_GREEN);
            lamp_y  <= w_yel_nxt || ((w_nxt == S_OFF) && w_blink_nxt);
            busy    <= w_yel_nxt;
            done    <= w_done_nxt;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_semaphore_head.sv
`default_nettype none
// ============================================================================
// Module   : tb_semaphore_head
// Purpose  : Scoreboard bench for semaphore_head (CYCLES_PER_SEC=4, YELLOW_S=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_semaphore_head;

    logic       CLK = 1'b0;
    logic       reset, en, set, change;
    logic       lamp_r, lamp_y, lamp_g, busy, done;
    logic [2:0] state;

    typedef struct {
        int         id;
        logic [7:0] v;   // {state, r, y, g, busy, done}
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    semaphore_head #(
        .CYCLES_PER_SEC(4),
        .YELLOW_S      (3),
        .CNT_W         (8)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .en    (en),
        .set   (set),
        .change(change),
        .lamp_r(lamp_r),
        .lamp_y(lamp_y),
        .lamp_g(lamp_g),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 CLK = ~CLK;

    // Apply inputs for one edge and queue the outputs expected after it.
    task automatic step(input logic rs, input logic e, input logic s, input logic c,
                        input logic [2:0] st, input logic bl, input logic d);
        exp_t x;
        logic yel;
        yel    = (st == 3'd3) || (st == 3'd4);
        reset  = rs;
        en     = e;
        set    = s;
        change = c;
        x.id   = step_id;
        x.v    = {st, (st == 3'd1), yel || ((st == 3'd0) && bl), (st == 3'd2), yel, d};
        sbq.push_back(x);
        step_id++;
        @(posedge CLK);
        #1;
    endtask

    // Change from a stable colour: 12 yellow cycles, then the target with done.
    // The second change pulse (at yellow cycle 'extra_at', 0 = none) must be ignored.
    task automatic yellow_run(input logic [2:0] yst, input logic [2:0] tgt, input int extra_at);
        step(1'b0, 1'b1, 1'b0, 1'b1, yst, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, (i == extra_at), yst, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, tgt, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t       x;
        logic [7:0] act;
        forever begin
            @(negedge CLK);
            if (sbq.size() > 0) begin
                x   = sbq.pop_front();
                act = {state, lamp_r, lamp_y, lamp_g, busy, done};
                n_chk++;
                if (act !== x.v) begin
                    n_fail++;
                    $display("FAIL step %0d {st,r,y,g,busy,done}: got %b_%b required %b_%b",
                             x.id, act[7:5], act[4:0], x.v[7:5], x.v[4:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1; en = 1'b0; set = 1'b0; change = 1'b0;
        // Reset held two cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        // Leave OFF into RED, no done
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        // RED -> YEL2G -> GREEN
        yellow_run(3'd3, 3'd2, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        // GREEN -> YEL2R -> RED, second change 5 cycles in is ignored
        yellow_run(3'd4, 3'd1, 5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        // Back to GREEN, then change and abort mid-YEL2R (6th yellow cycle)
        yellow_run(3'd3, 3'd2, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        end
        // en drop together with change: OFF wins, dark, no done
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        // OFF flashing: 4 dark, 4 lit, ... (change in OFF ignored)
        for (int k = 1; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b1, (k == 9), 3'd0, ((k / 4) % 2 == 1), 1'b0);
        end
        // Re-enable with set=0 -> GREEN
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
        // GREEN -> RED -> GREEN, then change in the done cycle is accepted
        yellow_run(3'd4, 3'd1, 0);
        yellow_run(3'd3, 3'd2, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        // Reset mid-yellow wins over everything
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
